// File: rtl/exec_commit_unit_pkg.sv
// Shared types and constants for the execute-stage condition/commit logic.
package exec_commit_unit_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/exec_commit_unit_cond_check.sv
// Combinational ARM condition evaluation of CondE against the NZCV flags.
// Zero latency; no flow control.
module cond_check
  import exec_commit_unit_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] FlagsQ,
  output logic       CondExE
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = FlagsQ[FLAG_N];
  assign w_z = FlagsQ[FLAG_Z];
  assign w_c = FlagsQ[FLAG_C];
  assign w_v = FlagsQ[FLAG_V];

  always_comb begin
    CondExE = 1'b0;
    case (cond_t'(CondE))
      COND_EQ: CondExE = w_z;
      COND_NE: CondExE = ~w_z;
      COND_CS: CondExE = w_c;
      COND_CC: CondExE = ~w_c;
      COND_MI: CondExE = w_n;
      COND_PL: CondExE = ~w_n;
      COND_VS: CondExE = w_v;
      COND_VC: CondExE = ~w_v;
      COND_HI: CondExE = w_c & ~w_z;
      COND_LS: CondExE = ~w_c | w_z;
      COND_GE: CondExE = (w_n == w_v);
      COND_LT: CondExE = (w_n != w_v);
      COND_GT: CondExE = ~w_z & (w_n == w_v);
      COND_LE: CondExE = w_z | (w_n != w_v);
      COND_AL: CondExE = 1'b1;
      COND_NV: CondExE = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_commit_unit.sv
// Execute-stage commit: NZCV flag register, condition gating and the E->M register.
// One cycle E->M latency; StallE/FlushE insert a bubble and block flag commits.
module exec_commit_unit
  import exec_commit_unit_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallE,
  input  logic         FlushE,
  input  logic [3:0]   CondE,
  input  logic [1:0]   FlagWriteE,
  input  logic [3:0]   ALUFlags,
  input  logic         RegWriteE,
  input  logic         MemWriteE,
  input  logic         MemtoRegE,
  input  logic         PCSrcE,
  input  logic         BranchE,
  input  logic [3:0]   WA3E,
  input  logic [n-1:0] ALUResultE,
  input  logic [n-1:0] WriteDataE,
  output logic         CondExE,
  output logic         BranchTakenE,
  output logic [3:0]   FlagsQ,
  output logic         RegWriteM,
  output logic         MemWriteM,
  output logic         MemtoRegM,
  output logic         PCSrcM,
  output logic [3:0]   WA3M,
  output logic [n-1:0] ALUResultM,
  output logic [n-1:0] WriteDataM
);

  logic [3:0]   r_flags;
  logic         r_reg_write, r_mem_write, r_mem_to_reg, r_pc_src;
  logic [3:0]   r_wa3;
  logic [n-1:0] r_alu_result, r_write_data;

  logic w_cond_ex;
  logic w_bubble;
  logic w_commit;

  cond_check u_cond_check (
    .CondE   (CondE),
    .FlagsQ  (r_flags),
    .CondExE (w_cond_ex)
  );

  assign w_bubble = StallE | FlushE;
  assign w_commit = w_cond_ex & ~w_bubble;

  // NZ and CV halves update independently; an unwritten half holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (FlagWriteE[FW_NZ] && w_commit) begin
        r_flags[FLAG_N] <= ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagWriteE[FW_CV] && w_commit) begin
        r_flags[FLAG_C] <= ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  // A failed condition still carries data forward; only write enables drop.
  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc_src     <= 1'b0;
      r_wa3        <= 4'b0000;
      r_alu_result <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write  <= RegWriteE & w_cond_ex;
      r_mem_write  <= MemWriteE & w_cond_ex;
      r_mem_to_reg <= MemtoRegE;
      r_pc_src     <= PCSrcE & w_cond_ex;
      r_wa3        <= WA3E;
      r_alu_result <= ALUResultE;
      r_write_data <= WriteDataE;
    end
  end

  assign CondExE      = w_cond_ex;
  assign BranchTakenE = BranchE & w_commit;
  assign FlagsQ       = r_flags;
  assign RegWriteM    = r_reg_write;
  assign MemWriteM    = r_mem_write;
  assign MemtoRegM    = r_mem_to_reg;
  assign PCSrcM       = r_pc_src;
  assign WA3M         = r_wa3;
  assign ALUResultM   = r_alu_result;
  assign WriteDataM   = r_write_data;

endmodule

// File: tb/tb_exec_commit_unit.sv
// Scoreboard bench for exec_commit_unit: expected M/flag state queued per cycle.
module tb_exec_commit_unit;

  logic        clk = 1'b0;
  logic        reset, StallE, FlushE;
  logic [3:0]  CondE;
  logic [1:0]  FlagWriteE;
  logic [3:0]  ALUFlags;
  logic        RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE;
  logic [3:0]  WA3E;
  logic [31:0] ALUResultE, WriteDataE;
  logic        CondExE, BranchTakenE;
  logic [3:0]  FlagsQ;
  logic        RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic [3:0]  WA3M;
  logic [31:0] ALUResultM, WriteDataM;

  typedef struct packed {
    logic        rw, mw, m2r, pcs;
    logic [3:0]  wa3;
    logic [31:0] res, wd;
  } mrec_t;

  typedef struct packed {
    mrec_t      m;
    logic [3:0] f;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_flags;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  exec_commit_unit #(.n(32)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .PCSrcE(PCSrcE), .BranchE(BranchE), .WA3E(WA3E),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .FlagsQ(FlagsQ),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM), .WA3M(WA3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
  );

  // Reference condition: base test on cond[3:1], inverted by cond[0].
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic nn, zz, cc, vv, b;
    {nn, zz, cc, vv} = f;
    case (c[3:1])
      3'd0: b = zz;
      3'd1: b = cc;
      3'd2: b = nn;
      3'd3: b = vv;
      3'd4: b = cc && !zz;
      3'd5: b = (nn == vv);
      3'd6: b = !zz && (nn == vv);
      default: b = 1'b1;
    endcase
    return (c == 4'b1111) ? 1'b0 : (b ^ c[0]);
  endfunction

  function automatic mrec_t dut_m();
    return {RegWriteM, MemWriteM, MemtoRegM, PCSrcM, WA3M, ALUResultM, WriteDataM};
  endfunction

  task automatic idle_inputs();
    reset = 0; StallE = 0; FlushE = 0; CondE = 4'b1110; FlagWriteE = 2'b00;
    ALUFlags = 0; RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0;
    BranchE = 0; WA3E = 0; ALUResultE = 0; WriteDataE = 0;
  endtask

  // Predict the state after the coming edge, queue it, then advance one cycle.
  task automatic tick();
    exp_t       e;
    logic       c, bub, com;
    logic [3:0] nf;
    c   = ref_cond(CondE, m_flags);
    bub = StallE || FlushE;
    com = c && !bub;
    nf  = m_flags;
    if (reset) begin
      e.m = '0;
      nf  = 4'b0000;
    end else begin
      if (bub) e.m = '0;
      else e.m = {RegWriteE && c, MemWriteE && c, MemtoRegE, PCSrcE && c,
                  WA3E, ALUResultE, WriteDataE};
      if (FlagWriteE[1] && com) nf[3:2] = ALUFlags[3:2];
      if (FlagWriteE[0] && com) nf[1:0] = ALUFlags[1:0];
    end
    e.f = nf;
    sb.push_back(e);
    m_flags = nf;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    reset = 1; StallE = 1; FlushE = 1; RegWriteE = 1;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e) $display("FAIL reset_state: got %h want %h", {dut_m(), FlagsQ}, e);
    else passes++;
    checks++;
    if (FlagsQ !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", FlagsQ);
    else passes++;
    idle_inputs();
    CondE = 4'b0000; RegWriteE = 1; ALUResultE = 32'h1234;
    #1;
    checks++;
    if (CondExE !== 1'b0) $display("FAIL reset_eq_fails: got %b want 0", CondExE);
    else passes++;
    CondE = 4'b0001;
    #1;
    checks++;
    if (CondExE !== 1'b1) $display("FAIL reset_ne_passes: got %b want 1", CondExE);
    else passes++;
    CondE = 4'b0000;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e) $display("FAIL reset_eq_commit: got %h want %h", {dut_m(), FlagsQ}, e);
    else passes++;
    checks++;
    if (RegWriteM !== 1'b0 || ALUResultM !== 32'h1234)
      $display("FAIL reset_eq_regwrite: got rw=%b res=%h want rw=0 res=00001234", RegWriteM, ALUResultM);
    else passes++;
  endtask

  task automatic test_flag_write();
    exp_t e;
    idle_inputs();
    CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || FlagsQ !== 4'b0100)
      $display("FAIL flag_write: got flags=%b want 0100", FlagsQ);
    else passes++;
    idle_inputs();
    CondE = 4'b0000; BranchE = 1;
    #1;
    checks++;
    if (BranchTakenE !== 1'b1 || CondExE !== 1'b1)
      $display("FAIL flag_use_branch: got bt=%b cx=%b want 1 1", BranchTakenE, CondExE);
    else passes++;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e) $display("FAIL flag_use_m: got %h want %h", {dut_m(), FlagsQ}, e);
    else passes++;
  endtask

  task automatic test_partial_flags();
    exp_t e;
    idle_inputs();
    FlagWriteE = 2'b11; ALUFlags = 4'b0011;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || FlagsQ !== 4'b0011) $display("FAIL partial_setup: got %b want 0011", FlagsQ);
    else passes++;
    FlagWriteE = 2'b10; ALUFlags = 4'b1000;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || FlagsQ !== 4'b1011) $display("FAIL partial_nz: got %b want 1011", FlagsQ);
    else passes++;
    FlagWriteE = 2'b01; ALUFlags = 4'b0100;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || FlagsQ !== 4'b1000) $display("FAIL partial_cv: got %b want 1000", FlagsQ);
    else passes++;
  endtask

  task automatic test_signed_conds();
    logic [3:0] cv;
    logic [3:0] want;
    idle_inputs();
    want = 4'b0110;  // GE, LT, LE, GT expected with N=1, V=0
    for (int i = 0; i < 4; i++) begin
      cv = (i == 0) ? 4'b1010 : (i == 1) ? 4'b1011 : (i == 2) ? 4'b1101 : 4'b1100;
      CondE = cv;
      #1;
      checks++;
      if (CondExE !== want[3-i]) $display("FAIL signed_cond_%b: got %b want %b", cv, CondExE, want[3-i]);
      else passes++;
    end
    for (int i = 0; i < 16; i++) begin
      CondE = 4'(i);
      #1;
      checks++;
      if (CondExE !== ref_cond(CondE, m_flags))
        $display("FAIL cond_sweep_%b: got %b want %b", CondE, CondExE, ref_cond(CondE, m_flags));
      else passes++;
    end
  endtask

  task automatic test_stall();
    exp_t e;
    idle_inputs();
    CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b1111;
    ALUResultE = 32'h0000_00AA; RegWriteE = 1; WA3E = 4'd5; StallE = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({dut_m(), FlagsQ} !== e || FlagsQ !== 4'b1000 || RegWriteM !== 1'b0)
        $display("FAIL stall_hold_%0d: got %h want %h", i, {dut_m(), FlagsQ}, e);
      else passes++;
    end
    StallE = 0;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || FlagsQ !== 4'b1111 || ALUResultM !== 32'hAA || RegWriteM !== 1'b1)
      $display("FAIL stall_release: got %h want %h", {dut_m(), FlagsQ}, e);
    else passes++;
    idle_inputs();
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || RegWriteM !== 1'b0)
      $display("FAIL stall_once: got rw=%b want 0", RegWriteM);
    else passes++;
  endtask

  task automatic test_flush_and_nv();
    exp_t e;
    idle_inputs();
    FlushE = 1; MemWriteE = 1; BranchE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0000;
    #1;
    checks++;
    if (BranchTakenE !== 1'b0) $display("FAIL flush_branch: got %b want 0", BranchTakenE);
    else passes++;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || MemWriteM !== 1'b0 || FlagsQ !== 4'b1111)
      $display("FAIL flush_bubble: got %h want %h", {dut_m(), FlagsQ}, e);
    else passes++;
    idle_inputs();
    CondE = 4'b1111; MemWriteE = 1; RegWriteE = 1; PCSrcE = 1; BranchE = 1;
    FlagWriteE = 2'b11; ALUFlags = 4'b0000; ALUResultE = 32'hDEAD_BEEF; WA3E = 4'd9;
    #1;
    checks++;
    if (CondExE !== 1'b0 || BranchTakenE !== 1'b0)
      $display("FAIL nv_cond: got cx=%b bt=%b want 0 0", CondExE, BranchTakenE);
    else passes++;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || {RegWriteM, MemWriteM, PCSrcM} !== 3'b000 ||
        ALUResultM !== 32'hDEAD_BEEF || FlagsQ !== 4'b1111)
      $display("FAIL nv_no_write: got %h want %h", {dut_m(), FlagsQ}, e);
    else passes++;
    // Self-referencing flag setter whose condition fails (Z=1 so NE fails).
    CondE = 4'b0001;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || FlagsQ !== 4'b1111)
      $display("FAIL cond_fail_flags: got %b want 1111", FlagsQ);
    else passes++;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    idle_inputs();
    reset = 1; StallE = 1; FlushE = 0; RegWriteE = 1; ALUResultE = 32'h55;
    tick();
    e = sb.pop_front();
    checks++;
    if ({dut_m(), FlagsQ} !== e || FlagsQ !== 4'b0000)
      $display("FAIL mid_reset: got %h want %h", {dut_m(), FlagsQ}, e);
    else passes++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      reset      = ($urandom_range(0, 29) == 0);
      StallE     = ($urandom_range(0, 4) == 0);
      FlushE     = ($urandom_range(0, 5) == 0);
      CondE      = 4'($urandom_range(0, 15));
      FlagWriteE = 2'($urandom_range(0, 3));
      ALUFlags   = 4'($urandom_range(0, 15));
      RegWriteE  = 1'($urandom_range(0, 1));
      MemWriteE  = 1'($urandom_range(0, 1));
      MemtoRegE  = 1'($urandom_range(0, 1));
      PCSrcE     = 1'($urandom_range(0, 1));
      BranchE    = 1'($urandom_range(0, 1));
      WA3E       = 4'($urandom_range(0, 15));
      ALUResultE = $urandom;
      WriteDataE = $urandom;
      #1;
      checks++;
      if (CondExE !== ref_cond(CondE, m_flags) ||
          BranchTakenE !== (BranchE && ref_cond(CondE, m_flags) && !StallE && !FlushE))
        $display("FAIL b2b_comb_%0d: got cx=%b bt=%b", i, CondExE, BranchTakenE);
      else passes++;
      tick();
      e = sb.pop_front();
      checks++;
      if ({dut_m(), FlagsQ} !== e) $display("FAIL b2b_m_%0d: got %h want %h", i, {dut_m(), FlagsQ}, e);
      else passes++;
    end
  endtask

  initial begin
    m_flags = 4'b0000;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_flag_write();
    test_partial_flags();
    test_signed_conds();
    test_stall();
    test_flush_and_nv();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
